fir_coef_loader: RTL and testbench
==================================

FIR_COEF_LOADER -- requirements
Module: fir_coef_loader

Interface
REQ-001 Parameter NUM_TAPS, default 64: number of coefficients written per load sequence.
REQ-002 Parameter ADDR_W, default 6: width of caddr; NUM_TAPS SHALL be at most 2^ADDR_W.
REQ-003 Parameter GAP_CYCLES, default 10: idle cycles inserted after the last write before done.
REQ-004 Parameter TIMEOUT, default 255: maximum stall cycles allowed between accepted coefficients.
REQ-005 clk2  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 start  input  1  one-cycle request to begin a load sequence.
REQ-008 abort  input  1  terminate the current sequence.
REQ-009 s_data  input  16  signed coefficient from the source.
REQ-010 s_valid  input  1  s_data valid.
REQ-011 s_ready  output  1  loader accepts s_data this cycle.
REQ-012 cin  output  16  signed coefficient to the FIR core.
REQ-013 caddr  output  ADDR_W  tap address to the FIR core.
REQ-014 cload  output  1  coefficient write strobe to the FIR core.
REQ-015 busy  output  1  high in LOAD or GAP.
REQ-016 done  output  1  one-cycle pulse on successful completion.
REQ-017 err  output  1  sticky timeout flag.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, LOAD, GAP, ERR.
REQ-019 IDLE: start=1 -> LOAD; tap index cleared to 0; stall counter cleared; err cleared.
REQ-020 LOAD: s_ready=1 combinationally; a beat is accepted when s_valid and s_ready are both 1.
REQ-021 Accepted beat in cycle N -> in cycle N+1 cload=1, caddr=index, cin=s_data; all three are registered outputs.
REQ-022 No accept in cycle N -> cload=0 in cycle N+1; caddr and cin hold their last values.
REQ-023 Index SHALL increment by 1 per accept with no skipped or repeated addresses, 0 through NUM_TAPS-1.
REQ-024 Accept of index NUM_TAPS-1 -> GAP next cycle; s_ready=0 from that cycle; that final cload pulse still occurs.
REQ-025 GAP: cload=0; count GAP_CYCLES cycles, then assert done for one cycle and enter IDLE.
REQ-026 Stall counter: increments each LOAD cycle without an accept; clears on accept.
REQ-027 Stall counter reaching TIMEOUT -> ERR next cycle; err=1; s_ready=0; cload=0.
REQ-028 ERR: holds err=1; start -> LOAD with err cleared, as in REQ-019; abort -> IDLE with err held.
REQ-029 abort in LOAD or GAP SHALL have priority over accept and timeout in the same cycle.
REQ-030 abort in LOAD or GAP -> IDLE next cycle; cload=0; done not pulsed; index not written further.
REQ-031 start while busy or in the same cycle as abort SHALL be ignored.
REQ-032 start and a timeout expiry cannot coincide; in IDLE, abort SHALL be ignored.
REQ-033 done SHALL never assert in the same cycle as cload or err rising.

Reset
REQ-034 rst=1 SHALL have priority over all inputs and force IDLE on the next edge.
REQ-035 Under reset: s_ready=0, cin=0, caddr=0, cload=0, busy=0, done=0, err=0, index=0, counters=0.
REQ-036 Reset mid-LOAD or mid-GAP SHALL produce no further cload or done pulse.

Verification
REQ-037 Full load: start, then s_valid held high with s_data=100+i -> 64 consecutive cload cycles, caddr 0..63, cin 100..163, first cload two cycles after start, GAP of 10 cycles, done one cycle, busy low afterwards.
REQ-038 Bursty source: s_valid toggled on alternate cycles -> cload pulses only after accepts; caddr strictly sequential; total 64 writes; done asserts once.
REQ-039 Timeout: start, 5 beats, then s_valid=0 for 255 cycles -> err=1; cload stops after caddr=4; subsequent start clears err and restarts at caddr=0.
REQ-040 Abort: abort at index 30 coincident with s_valid=1 -> no write of index 30; IDLE next cycle; done never asserts; busy=0.
REQ-041 Reset mid-GAP: rst at GAP cycle 3 -> done never asserts; all outputs 0 next cycle; a new start completes a normal load.
REQ-042 Ignored start: start pulsed during LOAD at index 10 -> sequence continues uninterrupted; exactly 64 writes; exactly one done pulse.

Source files
------------

// File: rtl/fir_coef_loader.sv
`default_nettype none
// ============================================================================
// Module   : fir_coef_loader
// Brief    : Streams NUM_TAPS signed coefficients from a ready/valid source
//            into a FIR core's coefficient port, with stall timeout and abort.
// Revision : 1.0 - initial release
// ============================================================================
module fir_coef_loader #(
    parameter int NUM_TAPS   = 64,
    parameter int ADDR_W     = 6,
    parameter int GAP_CYCLES = 10,
    parameter int TIMEOUT    = 255
) (
    input  logic                clk2,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic signed [15:0]  s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic signed [15:0]  cin,
    output logic [ADDR_W-1:0]   caddr,
    output logic                cload,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LOAD = 2'd1;
    localparam logic [1:0] c_GAP  = 2'd2;
    localparam logic [1:0] c_ERR  = 2'd3;

    localparam int c_STALL_W = $clog2(TIMEOUT + 1);
    localparam int c_GAP_W   = $clog2(GAP_CYCLES + 1);

    localparam logic [ADDR_W-1:0]    c_LAST_IDX   = ADDR_W'(NUM_TAPS - 1);
    localparam logic [c_STALL_W-1:0] c_STALL_LAST = c_STALL_W'(TIMEOUT - 1);
    localparam logic [c_GAP_W-1:0]   c_GAP_LAST   = c_GAP_W'(GAP_CYCLES - 1);

    logic [1:0]               r_state;
    logic [ADDR_W-1:0]        r_idx;
    logic [c_STALL_W-1:0]     r_stall;
    logic [c_GAP_W-1:0]       r_gap;
    logic signed [15:0]       r_cin;
    logic [ADDR_W-1:0]        r_caddr;
    logic                     r_cload;
    logic                     r_done;
    logic                     r_err;

    logic                     w_accept;
    logic                     w_start_ok;

    // A beat offered alongside abort or reset is not consumed.
    assign s_ready    = (r_state == c_LOAD) & ~abort & ~rst;
    assign w_accept   = s_ready & s_valid;
    assign w_start_ok = start & ~abort;

    always_ff @(posedge clk2) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_idx   <= '0;
            r_stall <= '0;
            r_gap   <= '0;
            r_cin   <= '0;
            r_caddr <= '0;
            r_cload <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_cload <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_start_ok) begin
                        r_state <= c_LOAD;
                        r_idx   <= '0;
                        r_stall <= '0;
                        r_err   <= 1'b0;
                    end
                end
                c_LOAD: begin
                    if (abort) begin
                        r_state <= c_IDLE;
                    end else if (w_accept) begin
                        r_cload <= 1'b1;
                        r_caddr <= r_idx;
                        r_cin   <= s_data;
                        r_stall <= '0;
                        r_idx   <= r_idx + ADDR_W'(1);
                        if (r_idx == c_LAST_IDX) begin
                            r_state <= c_GAP;
                            r_gap   <= '0;
                        end
                    end else begin
                        r_stall <= r_stall + c_STALL_W'(1);
                        if (r_stall == c_STALL_LAST) begin
                            r_state <= c_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
                c_GAP: begin
                    if (abort) begin
                        r_state <= c_IDLE;
                    end else if (r_gap == c_GAP_LAST) begin
                        r_state <= c_IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_gap <= r_gap + c_GAP_W'(1);
                    end
                end
                default: begin
                    // Error state: abort parks in IDLE with err still visible.
                    if (abort) begin
                        r_state <= c_IDLE;
                    end else if (start) begin
                        r_state <= c_LOAD;
                        r_idx   <= '0;
                        r_stall <= '0;
                        r_err   <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign cin   = r_cin;
    assign caddr = r_caddr;
    assign cload = r_cload;
    assign done  = r_done;
    assign err   = r_err;
    assign busy  = (r_state == c_LOAD) | (r_state == c_GAP);

endmodule
`default_nettype wire

// File: tb/tb_fir_coef_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_coef_loader
// Brief    : Randomized self-checking bench; expectations come from a
//            per-scenario model evaluated over the stimulus arrays.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_coef_loader;

    localparam int NUM_TAPS = 64;
    localparam int ADDR_W   = 6;
    localparam int GAP      = 10;
    localparam int TMO      = 255;
    localparam int MAXT     = 640;

    logic clk2 = 1'b0;
    logic rst, start, abort, s_valid, s_ready, cload, busy, done, err;
    logic signed [15:0] s_data, cin;
    logic [ADDR_W-1:0]  caddr;

    fir_coef_loader #(
        .NUM_TAPS(NUM_TAPS), .ADDR_W(ADDR_W), .GAP_CYCLES(GAP), .TIMEOUT(TMO)
    ) dut (
        .clk2(clk2), .rst(rst), .start(start), .abort(abort),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .cin(cin), .caddr(caddr), .cload(cload),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk2 = ~clk2;

    // scenario stimulus, cycle 0 is the start cycle
    bit vpat [MAXT];
    int dpat [MAXT];
    int abort_at, rst_at, start_at;

    // model expectations
    int exp_wr_t[$], exp_wr_a[$], exp_wr_d[$];
    int exp_ready [MAXT];
    int done_t, err_t, last_busy, last_t, prev_err;
    bit started;

    // observations
    int obs_cload [MAXT], obs_caddr [MAXT], obs_cin [MAXT], obs_done [MAXT];
    int obs_err [MAXT], obs_busy [MAXT], obs_ready [MAXT];

    int n_checks, n_pass;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic clear_scn();
        abort_at = -1;
        rst_at   = -1;
        start_at = -1;
    endtask

    task automatic gen_pat(input int dens);
        logic signed [15:0] v;
        for (int t = 0; t < MAXT; t++) begin
            v       = 16'($urandom);
            dpat[t] = v;
            vpat[t] = ($urandom_range(0, 99) < dens) && (t > 0);
        end
    endtask

    // cycle at which the n-th beat (0-based) is offered
    function automatic int nth_valid(input int n);
        int cnt;
        cnt = 0;
        for (int t = 1; t < MAXT; t++) begin
            if (vpat[t]) begin
                if (cnt == n) return t;
                cnt++;
            end
        end
        return MAXT - 3;
    endfunction

    // Walk the stimulus: each offered beat while loading is a write one cycle
    // later; a run of TMO idle cycles is a timeout; abort/reset cut it short.
    task automatic model_predict();
        int acc, stall;
        bit fin;
        exp_wr_t.delete(); exp_wr_a.delete(); exp_wr_d.delete();
        for (int t = 0; t < MAXT; t++) exp_ready[t] = 0;
        done_t = -1; err_t = -1; last_busy = 0; last_t = MAXT - 3;
        started = (abort_at != 0) && (rst_at != 0);
        if (!started) begin
            last_t = 0;
            return;
        end
        acc = 0; stall = 0; fin = 0;
        for (int t = 1; t < MAXT - 3 && !fin; t++) begin
            if (t == rst_at || t == abort_at) begin
                exp_ready[t] = 2;
                last_busy = t; last_t = t; fin = 1;
            end else begin
                exp_ready[t] = 1;
                if (vpat[t]) begin
                    exp_wr_t.push_back(t + 1);
                    exp_wr_a.push_back(acc);
                    exp_wr_d.push_back(dpat[t]);
                    acc++; stall = 0;
                    if (acc == NUM_TAPS) begin
                        fin = 1;
                        last_busy = t + GAP; done_t = t + GAP + 1; last_t = done_t;
                        for (int g = t + 1; g <= t + GAP; g++) begin
                            if ((g == rst_at || g == abort_at) && done_t >= 0) begin
                                last_busy = g; done_t = -1; last_t = g;
                            end
                        end
                    end
                end else begin
                    stall++;
                    if (stall == TMO) begin
                        err_t = t + 1; last_busy = t; last_t = err_t; fin = 1;
                    end
                end
            end
        end
    endtask

    task automatic run_scn(input string nm);
        int ow_t[$], ow_a[$], ow_d[$];
        int bad_busy, bad_ready, bad_err, bad_done, n, e_err;
        model_predict();
        for (int t = 0; t <= last_t + 2; t++) begin
            @(posedge clk2); #1;
            start   = (t == 0) || (t == start_at);
            abort   = (t == abort_at);
            rst     = (t == rst_at);
            s_valid = vpat[t];
            s_data  = 16'(dpat[t]);
            @(negedge clk2);
            obs_cload[t] = int'(cload);
            obs_caddr[t] = int'(caddr);
            obs_cin[t]   = int'(cin);
            obs_done[t]  = int'(done);
            obs_err[t]   = int'(err);
            obs_busy[t]  = int'(busy);
            obs_ready[t] = int'(s_ready);
        end
        @(posedge clk2); #1;
        start = 0; abort = 0; rst = 0; s_valid = 0;

        bad_busy = 0; bad_ready = 0; bad_err = 0; bad_done = 0;
        for (int t = 0; t <= last_t + 2; t++) begin
            if (obs_cload[t] != 0) begin
                ow_t.push_back(t); ow_a.push_back(obs_caddr[t]); ow_d.push_back(obs_cin[t]);
            end
            if (obs_busy[t] != int'(t >= 1 && t <= last_busy && started)) bad_busy++;
            if (exp_ready[t] != 2 && obs_ready[t] != exp_ready[t]) bad_ready++;
            if (obs_done[t] != int'(t == done_t)) bad_done++;
            e_err = (t == 0 || !started) ? prev_err : int'(err_t >= 0 && t >= err_t);
            if (obs_err[t] != e_err) bad_err++;
        end
        chk({nm, ".nwr"}, ow_t.size(), exp_wr_t.size());
        n = (ow_t.size() < exp_wr_t.size()) ? ow_t.size() : exp_wr_t.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s.wr%0d_cyc", nm, i), ow_t[i], exp_wr_t[i]);
            chk($sformatf("%s.wr%0d_addr", nm, i), ow_a[i], exp_wr_a[i]);
            chk($sformatf("%s.wr%0d_data", nm, i), ow_d[i], exp_wr_d[i]);
        end
        chk({nm, ".busy_bad_cycles"}, bad_busy, 0);
        chk({nm, ".ready_bad_cycles"}, bad_ready, 0);
        chk({nm, ".done_bad_cycles"}, bad_done, 0);
        chk({nm, ".err_bad_cycles"}, bad_err, 0);
        if (rst_at >= 0) begin
            chk({nm, ".post_rst_cin"},   obs_cin[rst_at + 1],   0);
            chk({nm, ".post_rst_caddr"}, obs_caddr[rst_at + 1], 0);
            chk({nm, ".post_rst_cload"}, obs_cload[rst_at + 1], 0);
            chk({nm, ".post_rst_busy"},  obs_busy[rst_at + 1],  0);
            chk({nm, ".post_rst_done"},  obs_done[rst_at + 1],  0);
            chk({nm, ".post_rst_err"},   obs_err[rst_at + 1],   0);
            chk({nm, ".post_rst_ready"}, obs_ready[rst_at + 1], 0);
        end
        if (started) prev_err = int'(err_t >= 0);
    endtask

    task automatic full_pat();
        for (int t = 0; t < MAXT; t++) begin
            vpat[t] = (t > 0);
            dpat[t] = 100 + t - 1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0; n_pass = 0; prev_err = 0;
        rst = 1; start = 0; abort = 0; s_valid = 1; s_data = 16'sh1234;
        repeat (3) @(posedge clk2);
        @(negedge clk2);
        chk("rst.cin",   int'(cin),     0);
        chk("rst.caddr", int'(caddr),   0);
        chk("rst.cload", int'(cload),   0);
        chk("rst.busy",  int'(busy),    0);
        chk("rst.done",  int'(done),    0);
        chk("rst.err",   int'(err),     0);
        chk("rst.ready", int'(s_ready), 0);
        @(posedge clk2); #1;
        rst = 0; s_valid = 0;

        clear_scn(); full_pat(); run_scn("full");

        clear_scn(); gen_pat(100);
        for (int t = 0; t < MAXT; t++) vpat[t] = (t % 2 == 1);
        run_scn("bursty");

        for (int k = 0; k < 3; k++) begin
            clear_scn(); gen_pat(int'($urandom_range(40, 90)));
            run_scn($sformatf("rand%0d", k));
        end

        clear_scn(); gen_pat(70); start_at = nth_valid(10); run_scn("ign_start");

        clear_scn(); gen_pat(70); abort_at = nth_valid(30); run_scn("abort_load");

        clear_scn(); gen_pat(100);
        for (int t = 0; t < MAXT; t++) vpat[t] = (t >= 1 && t <= 5);
        run_scn("timeout");

        clear_scn(); gen_pat(50); abort_at = 0; run_scn("err_abort");

        clear_scn(); gen_pat(80); run_scn("err_restart");

        clear_scn(); gen_pat(75);
        abort_at = nth_valid(NUM_TAPS - 1) + int'($urandom_range(1, GAP));
        run_scn("abort_gap");

        clear_scn(); gen_pat(75); rst_at = nth_valid(NUM_TAPS - 1) + 3; run_scn("rst_gap");

        clear_scn(); full_pat(); run_scn("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
